// File: rtl/tournament_predictor.sv
// Tournament branch predictor: gshare and local-history tables arbitrated by a
// chooser, with a speculative global history register restored on mispredict.
module tournament_predictor #(
  parameter int INDEX_BITS = 6,
  parameter int BHT_BITS   = 6,
  parameter int GHR_BITS   = 6,
  parameter int LHR_BITS   = 4,
  parameter int CNT_BITS   = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic [31:0]         cur_pc,
  input  logic                cur_is_branch,
  input  logic [31:0]         cur_target,
  output logic                pred_taken,
  output logic [31:0]         pred_pc,
  output logic                pred_gpred,
  output logic                pred_lpred,
  output logic                pred_use_global,
  output logic [GHR_BITS-1:0] pred_ghr,
  output logic [LHR_BITS-1:0] pred_lhist,
  input  logic                upd_valid,
  input  logic [31:0]         upd_pc,
  input  logic                upd_taken,
  input  logic                upd_mispredict,
  input  logic                upd_gpred,
  input  logic                upd_lpred,
  input  logic [GHR_BITS-1:0] upd_ghr,
  input  logic [LHR_BITS-1:0] upd_lhist
);

  localparam int N_ENT = 1 << INDEX_BITS;
  localparam int N_BHT = 1 << BHT_BITS;
  localparam int PC_HI = ((INDEX_BITS > BHT_BITS) ? INDEX_BITS : BHT_BITS) + 2;
  localparam logic [CNT_BITS-1:0] CNT_W    = {1'b0, {(CNT_BITS-1){1'b1}}};
  localparam logic [CNT_BITS-1:0] CNT_MAX  = {CNT_BITS{1'b1}};
  localparam logic [CNT_BITS-1:0] CNT_ZERO = {CNT_BITS{1'b0}};
  localparam logic [CNT_BITS-1:0] CNT_ONE  = {{(CNT_BITS-1){1'b0}}, 1'b1};

  function automatic logic [CNT_BITS-1:0] cnt_step(input logic [CNT_BITS-1:0] cnt,
                                                   input logic up);
    logic [CNT_BITS-1:0] nxt;
    if (up) begin
      nxt = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
    end else begin
      nxt = (cnt == CNT_ZERO) ? cnt : cnt - CNT_ONE;
    end
    return nxt;
  endfunction

  logic [CNT_BITS-1:0]   gsh_r [N_ENT];
  logic [CNT_BITS-1:0]   loc_r [N_ENT];
  logic [CNT_BITS-1:0]   sel_r [N_ENT];
  logic [LHR_BITS-1:0]   bht_r [N_BHT];
  logic [GHR_BITS-1:0]   ghr_r;

  logic [INDEX_BITS-1:0] cur_idx_s;
  logic [INDEX_BITS-1:0] cur_gidx_s;
  logic [INDEX_BITS-1:0] cur_lidx_s;
  logic [BHT_BITS-1:0]   cur_bidx_s;
  logic [INDEX_BITS-1:0] upd_idx_s;
  logic [INDEX_BITS-1:0] upd_gidx_s;
  logic [INDEX_BITS-1:0] upd_lidx_s;
  logic [BHT_BITS-1:0]   upd_bidx_s;
  logic                  upd_pc_unused_s;

  assign cur_idx_s  = cur_pc[INDEX_BITS+1:2];
  assign cur_bidx_s = cur_pc[BHT_BITS+1:2];
  assign cur_gidx_s = cur_idx_s ^ INDEX_BITS'(ghr_r);
  assign cur_lidx_s = cur_idx_s ^ INDEX_BITS'(pred_lhist);

  assign upd_idx_s  = upd_pc[INDEX_BITS+1:2];
  assign upd_bidx_s = upd_pc[BHT_BITS+1:2];
  assign upd_gidx_s = upd_idx_s ^ INDEX_BITS'(upd_ghr);
  assign upd_lidx_s = upd_idx_s ^ INDEX_BITS'(upd_lhist);
  assign upd_pc_unused_s = ^{upd_pc[31:PC_HI], upd_pc[1:0]};

  // Prediction reads pre-edge table state with no added latency.
  assign pred_lhist      = bht_r[cur_bidx_s];
  assign pred_ghr        = ghr_r;
  assign pred_gpred      = gsh_r[cur_gidx_s][CNT_BITS-1];
  assign pred_lpred      = loc_r[cur_lidx_s][CNT_BITS-1];
  assign pred_use_global = sel_r[cur_idx_s][CNT_BITS-1];
  assign pred_taken      = cur_is_branch & (pred_use_global ? pred_gpred : pred_lpred);
  assign pred_pc         = pred_taken ? cur_target : cur_pc + 32'd4;

  // Table training from resolved branches; BHT rebuilt from the returned snapshot.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_ENT; i++) begin
        gsh_r[i] <= CNT_W;
        loc_r[i] <= CNT_W;
        sel_r[i] <= CNT_W;
      end
      for (int i = 0; i < N_BHT; i++) begin
        bht_r[i] <= {LHR_BITS{1'b0}};
      end
    end else if (en && upd_valid) begin
      gsh_r[upd_gidx_s] <= cnt_step(gsh_r[upd_gidx_s], upd_taken);
      loc_r[upd_lidx_s] <= cnt_step(loc_r[upd_lidx_s], upd_taken);
      if (upd_gpred != upd_lpred) begin
        sel_r[upd_idx_s] <= cnt_step(sel_r[upd_idx_s], upd_gpred == upd_taken);
      end
      bht_r[upd_bidx_s] <= {upd_lhist[LHR_BITS-2:0], upd_taken};
    end
  end

  // Speculative global history; a mispredict recovery discards any wrong-path shift.
  always_ff @(posedge clk) begin
    if (reset) begin
      ghr_r <= {GHR_BITS{1'b0}};
    end else if (en) begin
      if (upd_valid && upd_mispredict) begin
        ghr_r <= {upd_ghr[GHR_BITS-2:0], upd_taken};
      end else if (cur_is_branch) begin
        ghr_r <= {ghr_r[GHR_BITS-2:0], pred_taken};
      end
    end
  end

endmodule

// File: doc/tournament_predictor.md
Name: tournament_predictor

Overview:
- Parametrised successor to the fixed 64-entry, 2-bit frontend predictor. Combines a gshare table, a local-history table and a chooser, with configurable table depth, history lengths and counter width.
- Adds a speculative global history register (GHR) with misprediction recovery.
- Sits in the fetch stage. Prediction is combinational on the fetch PC. Resolution arrives later from execute, carrying the history snapshot taken at predict time.

Parameters:
- INDEX_BITS, 6, log2 entries of the gshare, local and selector counter tables.
- BHT_BITS, 6, log2 entries of the local branch-history table.
- GHR_BITS, 6, global history length; must be ≤ INDEX_BITS.
- LHR_BITS, 4, local history length per BHT entry; must be ≤ INDEX_BITS.
- CNT_BITS, 2, saturating counter width; must be ≥ 2.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high; clears all state on the next clk edge
- en  in  1  global enable; when 0, no state changes
- cur_pc  in  32  fetch PC
- cur_is_branch  in  1  fetch instruction is a conditional branch
- cur_target  in  32  decoded branch target of cur_pc
- pred_taken  out  1  final prediction (0 if cur_is_branch=0)
- pred_pc  out  32  next fetch PC
- pred_gpred  out  1  gshare prediction (snapshot, for return on update)
- pred_lpred  out  1  local prediction (snapshot)
- pred_use_global  out  1  chooser selected gshare
- pred_ghr  out  GHR_BITS  current speculative GHR (snapshot)
- pred_lhist  out  LHR_BITS  local history read for cur_pc (snapshot)
- upd_valid  in  1  a branch resolves this cycle
- upd_pc  in  32  PC of resolved branch
- upd_taken  in  1  actual outcome
- upd_mispredict  in  1  final prediction was wrong
- upd_gpred, upd_lpred  in  1 each  snapshots returned
- upd_ghr  in  GHR_BITS  snapshot returned
- upd_lhist  in  LHR_BITS  snapshot returned

Behaviour:
- Index computation:
  - pcidx = pc[INDEX_BITS+1:2]; bidx = pc[BHT_BITS+1:2].
  - Histories are zero-extended to INDEX_BITS.
  - gshare index = pcidx ^ ghr; local index = pcidx ^ lhist; selector index = pcidx.
- Counters:
  - Saturating, CNT_BITS wide.
  - Reset value W = 2^(CNT_BITS-1)-1, i.e. weakly not-taken / weakly local.
  - Counter MSB=1 means predict taken; for the selector, MSB=1 means use gshare.
- Predict (combinational, zero latency, reads pre-edge state):
  - pred_lhist = BHT[bidx of cur_pc].
  - pred_taken = cur_is_branch & (use_global ? gpred : lpred).
  - pred_pc = pred_taken ? cur_target : cur_pc+4, with 32-bit wrap.
- Update, on clk when en & upd_valid & !reset:
  - gshare[pcidx(upd_pc)^upd_ghr] increments if upd_taken, else decrements; saturates at 0 and 2^CNT_BITS-1.
  - local[pcidx(upd_pc)^upd_lhist] is updated the same way.
  - Selector is updated only if upd_gpred != upd_lpred: increment if upd_gpred==upd_taken, else decrement.
  - BHT[bidx(upd_pc)] <= {upd_lhist[LHR_BITS-2:0], upd_taken}, i.e. rebuilt from the snapshot, not the current entry.
- GHR, on clk when en & !reset, in priority order:
  - (1) if upd_valid & upd_mispredict: ghr <= {upd_ghr[GHR_BITS-2:0], upd_taken}. This is recovery; any same-cycle fetch is wrong-path and its shift is discarded.
  - (2) else if cur_is_branch: ghr <= {ghr[GHR_BITS-2:0], pred_taken}.
  - (3) else hold.
- Simultaneous predict and update:
  - Prediction sees pre-update values.
  - No write-write conflict: the tables are written only by the update path.
- Reset:
  - All counters = W; BHT entries = 0; ghr = 0.
  - Reset overrides en and upd_valid, and clears immediately even mid-training.
- Post-reset outputs for any cur_pc: pred_taken=0, pred_gpred=0, pred_lpred=0, pred_use_global=0, pred_ghr=0, pred_lhist=0, pred_pc=cur_pc+4.
- en=0: all state held; outputs still combinationally valid.

Test Plan (default parameters):
- Reset, then cur_pc=0x104, cur_is_branch=1, cur_target=0x200 -> pred_taken=0, pred_pc=0x108, pred_ghr=0, pred_lhist=0.
- One update: upd_pc=0x104, taken=1, mispredict=0, all snapshots 0. Then predict 0x104 with cur_is_branch=1 -> pred_lhist=1, pred_gpred=1 (gshare[1]=2), pred_lpred=0 (local[0]=1), use_global=0, pred_taken=0, ghr then becomes 0b000000.
- Five taken updates at 0x104 with ghr=lhist=0 -> gshare[1]=3 (saturated). One not-taken update -> gshare[1]=2, pred_gpred still 1.
- Three fetch cycles with a taken-predicted branch -> ghr=0b000111. Then upd_mispredict=1, upd_ghr=0b000010, upd_taken=1, in the same cycle as a branch fetch -> ghr=0b000101.
- Update with upd_gpred=1, upd_lpred=0, upd_taken=1 at 0x104 -> selector[1] goes 1→2, pred_use_global=1. Repeat with gpred==lpred -> selector unchanged.
- en=0 with upd_valid=1 and a branch fetch -> no counter, BHT or ghr change. Assert reset after training -> all state back to reset values next cycle.
